// File: rtl/dose_log_pkg.sv
// Shared types and defaults for the dose log reader and its record buffer.
package dose_log_pkg;

    typedef enum logic [3:0] {
        IDLE,
        SAMPLE_T,
        PULSE_A,
        WAIT_A,
        SAMPLE_ID,
        PUSH,
        PULSE_B,
        WAIT_B,
        FINISH
    } state_t;

    localparam int unsigned REC_W          = 12;
    localparam int unsigned DEF_PULSE_LEN  = 2;
    localparam int unsigned DEF_SETTLE     = 3;
    localparam int unsigned DEF_FIFO_DEPTH = 4;

    localparam logic [4:0] MAX_COUNT = 5'd16;

    // Requests above the log capacity are clamped rather than wrapped.
    function automatic logic [4:0] sat_count(input logic [4:0] c);
        return (c > MAX_COUNT) ? MAX_COUNT : c;
    endfunction

endpackage

// File: rtl/dose_rec_fifo.sv
// Show-ahead record buffer; pointers carry one extra bit to tell full from empty.
module dose_rec_fifo
    import dose_log_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_FIFO_DEPTH,
    parameter int unsigned WIDTH = REC_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A pop frees the head slot in the same edge, so a push into a full buffer is safe then.
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // Pointer update on accepted push/pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Storage write; contents need no reset because empty masks the output.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/dose_log_reader.sv
// Reads a dose log out of the reminder by pressing its ACK button and sampling its display.
module dose_log_reader
    import dose_log_pkg::*;
#(
    parameter int unsigned PULSE_LEN  = DEF_PULSE_LEN,
    parameter int unsigned SETTLE     = DEF_SETTLE,
    parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [4:0] count,
    input  logic [7:0] lcd_in,
    output logic       ack_out,
    output logic       rec_valid,
    input  logic       rec_ready,
    output logic [7:0] rec_time,
    output logic [3:0] rec_med,
    output logic       busy,
    output logic       done,
    output logic       fmt_err
);

    localparam logic [3:0] PULSE_LOAD  = 4'(PULSE_LEN - 1);
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);

    state_t           state;
    state_t           state_d;
    logic [3:0]       cnt;
    logic [3:0]       cnt_d;
    logic [4:0]       remaining;
    logic [4:0]       remaining_d;
    logic [7:0]       time_q;
    logic [3:0]       med_q;
    logic             fifo_push;
    logic             fifo_full;
    logic             fifo_empty;
    logic [REC_W-1:0] fifo_dout;

    // Next-state, counter reload and push decision.
    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        remaining_d = remaining;
        fifo_push   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (count == '0) begin
                        state_d = FINISH;
                    end else begin
                        state_d     = SAMPLE_T;
                        remaining_d = sat_count(count);
                    end
                end
            end
            SAMPLE_T: begin
                state_d = PULSE_A;
                cnt_d   = PULSE_LOAD;
            end
            PULSE_A: begin
                if (cnt == '0) begin
                    state_d = WAIT_A;
                    cnt_d   = SETTLE_LOAD;
                end else begin
                    cnt_d = cnt - 4'd1;
                end
            end
            WAIT_A: begin
                if (cnt == '0) state_d = SAMPLE_ID;
                else           cnt_d   = cnt - 4'd1;
            end
            SAMPLE_ID: begin
                state_d = PUSH;
            end
            PUSH: begin
                if (!fifo_full) begin
                    fifo_push   = 1'b1;
                    remaining_d = remaining - 5'd1;
                    if (remaining == 5'd1) begin
                        state_d = FINISH;
                    end else begin
                        state_d = PULSE_B;
                        cnt_d   = PULSE_LOAD;
                    end
                end
            end
            PULSE_B: begin
                if (cnt == '0) begin
                    state_d = WAIT_B;
                    cnt_d   = SETTLE_LOAD;
                end else begin
                    cnt_d = cnt - 4'd1;
                end
            end
            WAIT_B: begin
                if (cnt == '0) state_d = SAMPLE_T;
                else           cnt_d   = cnt - 4'd1;
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counters and the registered ACK drive.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            remaining <= '0;
            ack_out   <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            remaining <= remaining_d;
            // Decoded from the next state so ACK is high exactly while in a pulse state.
            ack_out   <= (state_d == PULSE_A) || (state_d == PULSE_B);
        end
    end

    // Display sampling and the sticky format-error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            time_q  <= '0;
            med_q   <= '0;
            fmt_err <= 1'b0;
        end else begin
            if (state == IDLE && start) fmt_err <= 1'b0;
            if (state == SAMPLE_T) time_q <= lcd_in;
            if (state == SAMPLE_ID) begin
                med_q <= lcd_in[3:0];
                if (lcd_in[7:4] != '0) fmt_err <= 1'b1;
            end
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == FINISH);

    dose_rec_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (REC_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .din   ({time_q, med_q}),
        .pop   (rec_ready),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign rec_valid = !fifo_empty;
    assign rec_time  = fifo_dout[11:4];
    assign rec_med   = fifo_dout[3:0];

endmodule

// File: tb/tb_dose_log_reader.sv
// Bench for dose_log_reader: emulated reminder, behavioural timeline model and per-cycle compare.
module tb_dose_log_reader;

    localparam int unsigned PL    = 2;
    localparam int unsigned ST    = 3;
    localparam int unsigned DEPTH = 4;

    typedef struct {
        logic [7:0] t;
        logic [3:0] m;
    } rec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [4:0] count;
    logic [7:0] lcd_in;
    logic       ack_out;
    logic       rec_valid;
    logic       rec_ready;
    logic [7:0] rec_time;
    logic [3:0] rec_med;
    logic       busy;
    logic       done;
    logic       fmt_err;

    dose_log_reader #(
        .PULSE_LEN  (PL),
        .SETTLE     (ST),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .count     (count),
        .lcd_in    (lcd_in),
        .ack_out   (ack_out),
        .rec_valid (rec_valid),
        .rec_ready (rec_ready),
        .rec_time  (rec_time),
        .rec_med   (rec_med),
        .busy      (busy),
        .done      (done),
        .fmt_err   (fmt_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reminder log: time byte and raw ID byte per entry.
    logic [7:0] log_t  [64];
    logic [7:0] log_id [64];

    // Reminder display after p ACK presses: even -> time view, odd -> ID view of entry p/2.
    function automatic logic [7:0] view(input int p);
        int idx;
        idx = (p / 2) % 64;
        return ((p % 2) == 0) ? log_t[idx] : log_id[idx];
    endfunction

    // Reminder emulation plus press/done bookkeeping.
    int rp        = 0;
    int ack_rises = 0;
    int done_cnt  = 0;
    bit ack_d     = 1'b0;
    initial begin
        lcd_in = 8'h00;
        forever begin
            @(negedge clk);
            if (rst) begin
                rp    = 0;
                ack_d = 1'b0;
            end else begin
                if (ack_out && !ack_d) begin
                    rp++;
                    ack_rises++;
                end
                if (done) begin
                    done_cnt++;
                    if ((rp % 2) != 0) rp++;
                end
                ack_d = ack_out;
            end
            lcd_in = view(rp);
        end
    end

    // Records actually consumed at the following rising edge.
    rec_t popped[$];
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst && rec_valid && rec_ready) popped.push_back('{rec_time, rec_med});
        end
    end

    // ---------------- behavioural model ----------------
    bit         exp_ack  = 1'b0;
    bit         exp_busy = 1'b0;
    bit         exp_done = 1'b0;
    bit         exp_fmt  = 1'b0;
    rec_t       mq[$];
    int         mp       = 0;
    bit         aborted  = 1'b0;
    bit         start_s  = 1'b0;
    logic [4:0] cnt_s;
    rec_t       pend;

    task automatic clk_edge(input bit push_req, output bit pushed);
        bit was_full;
        @(posedge clk);
        pushed = 1'b0;
        if (rst) begin
            aborted  = 1'b1;
            mq.delete();
            exp_ack  = 1'b0;
            exp_busy = 1'b0;
            exp_done = 1'b0;
            exp_fmt  = 1'b0;
            mp       = 0;
            start_s  = 1'b0;
            return;
        end
        start_s  = start;
        cnt_s    = count;
        was_full = (mq.size() == DEPTH);
        if (rec_ready && mq.size() > 0) void'(mq.pop_front());
        if (push_req && !was_full) begin
            mq.push_back(pend);
            pushed = 1'b1;
        end
    endtask

    task automatic hold(input int c);
        bit p;
        for (int i = 0; i < c; i++) begin
            if (aborted) return;
            clk_edge(1'b0, p);
        end
    endtask

    task automatic run_seq(input int n);
        logic [7:0] t;
        logic [7:0] id;
        bit         p;
        exp_busy = 1'b1;
        exp_ack  = 1'b0;
        for (int k = 0; k < n; k++) begin
            t = view(mp);
            hold(1);           if (aborted) return;
            exp_ack = 1'b1; mp++;
            hold(PL);          if (aborted) return;
            exp_ack = 1'b0;
            hold(ST);          if (aborted) return;
            id = view(mp);
            hold(1);           if (aborted) return;
            if (id[7:4] != 4'h0) exp_fmt = 1'b1;
            pend = '{t, id[3:0]};
            p = 1'b0;
            while (!p) begin
                clk_edge(1'b1, p);
                if (aborted) return;
            end
            if (k == n - 1) begin
                exp_done = 1'b1;
                hold(1);       if (aborted) return;
                exp_done = 1'b0;
                exp_busy = 1'b0;
            end else begin
                exp_ack = 1'b1; mp++;
                hold(PL);      if (aborted) return;
                exp_ack = 1'b0;
                hold(ST);      if (aborted) return;
            end
        end
    endtask

    initial begin
        bit p;
        int n;
        forever begin
            clk_edge(1'b0, p);
            if (aborted) begin
                aborted = 1'b0;
                continue;
            end
            if (!start_s) continue;
            n = (cnt_s > 5'd16) ? 16 : int'(cnt_s);
            exp_fmt = 1'b0;
            if ((mp % 2) != 0) mp++;
            if (n == 0) begin
                exp_busy = 1'b1;
                exp_done = 1'b1;
                hold(1);
                if (!aborted) begin
                    exp_busy = 1'b0;
                    exp_done = 1'b0;
                end
            end else begin
                run_seq(n);
            end
            aborted = 1'b0;
        end
    end

    // Per-cycle compare of every output against the model.
    initial begin
        forever begin
            @(negedge clk);
            chk("ack_out",   ack_out,   exp_ack);
            chk("busy",      busy,      exp_busy);
            chk("done",      done,      exp_done);
            chk("fmt_err",   fmt_err,   exp_fmt);
            chk("rec_valid", rec_valid, (mq.size() > 0));
            chk("rec_time",  rec_time,  (mq.size() > 0) ? mq[0].t : 8'h00);
            chk("rec_med",   rec_med,   (mq.size() > 0) ? mq[0].m : 4'h0);
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_start(input int c);
        @(negedge clk);
        #1;
        start = 1'b1;
        count = 5'(c);
        @(negedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input int limit, input bit rnd);
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (rnd) begin
                #1;
                start = 1'b0;
            end
            if (!busy) break;
            if (rnd) begin
                rec_ready = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 30) == 0) begin
                    start = 1'b1;
                    count = 5'($urandom_range(0, 31));
                end
            end
        end
        chk("idle_reached", busy, 1'b0);
    endtask

    logic [11:0] exp6 [6];
    int a0;
    int d0;
    int ok;

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        count     = 5'd0;
        rec_ready = 1'b0;
        log_t[0] = 8'h05; log_id[0] = 8'h02;
        log_t[1] = 8'h09; log_id[1] = 8'h00;
        log_t[2] = 8'h0C; log_id[2] = 8'h03;
        log_t[3] = 8'h11; log_id[3] = 8'h01;
        log_t[4] = 8'h22; log_id[4] = 8'h05;
        log_t[5] = 8'h33; log_id[5] = 8'h07;
        log_t[6] = 8'h44; log_id[6] = 8'h00;
        log_t[7] = 8'h55; log_id[7] = 8'h09;
        log_t[8] = 8'h66; log_id[8] = 8'h0F;
        log_t[9] = 8'h70; log_id[9] = 8'h13;
        for (int i = 10; i < 64; i++) begin
            log_t[i]  = 8'($urandom);
            log_id[i] = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
        end
        exp6[0] = 12'h111; exp6[1] = 12'h225; exp6[2] = 12'h337;
        exp6[3] = 12'h440; exp6[4] = 12'h559; exp6[5] = 12'h66F;

        repeat (3) @(negedge clk);
        chk("rst_ack",   ack_out,   1'b0);
        chk("rst_busy",  busy,      1'b0);
        chk("rst_done",  done,      1'b0);
        chk("rst_valid", rec_valid, 1'b0);
        chk("rst_time",  rec_time,  8'h00);
        chk("rst_med",   rec_med,   4'h0);
        #1;
        rst = 1'b0;

        // Three-record log read with a willing consumer.
        rec_ready = 1'b1;
        popped.delete();
        d0 = done_cnt;
        do_start(3);
        wait_idle(500, 1'b0);
        repeat (2) @(negedge clk);
        chk("seq1_count", popped.size(), 3);
        if (popped.size() == 3) begin
            chk("seq1_rec0", {popped[0].t, popped[0].m}, 12'h052);
            chk("seq1_rec1", {popped[1].t, popped[1].m}, 12'h090);
            chk("seq1_rec2", {popped[2].t, popped[2].m}, 12'h0C3);
        end
        chk("seq1_done", done_cnt, d0 + 1);

        // Zero-length request.
        a0 = ack_rises;
        d0 = done_cnt;
        @(negedge clk);
        #1;
        start = 1'b1;
        count = 5'd0;
        @(negedge clk);
        chk("c0_done_hi", done, 1'b1);
        chk("c0_busy_hi", busy, 1'b1);
        #1;
        start = 1'b0;
        @(negedge clk);
        chk("c0_done_lo", done, 1'b0);
        chk("c0_busy_lo", busy, 1'b0);
        repeat (3) @(negedge clk);
        chk("c0_no_ack", ack_rises, a0);
        chk("c0_done_cnt", done_cnt, d0 + 1);

        // Back-pressure: six records into a four-entry buffer.
        #1;
        rec_ready = 1'b0;
        popped.delete();
        do_start(6);
        repeat (150) @(negedge clk);
        a0 = ack_rises;
        repeat (40) @(negedge clk);
        chk("stall_ack",   ack_out,   1'b0);
        chk("stall_busy",  busy,      1'b1);
        chk("stall_valid", rec_valid, 1'b1);
        chk("stall_press", ack_rises, a0);
        chk("stall_nopop", popped.size(), 0);
        #1;
        rec_ready = 1'b1;
        wait_idle(500, 1'b0);
        repeat (2) @(negedge clk);
        chk("stall_count", popped.size(), 6);
        ok = (popped.size() == 6);
        for (int i = 0; i < 6; i++) begin
            if (ok != 0) chk("stall_rec", {popped[i].t, popped[i].m}, exp6[i]);
        end

        // Malformed ID byte 0x13.
        #1;
        rec_ready = 1'b0;
        do_start(1);
        wait_idle(200, 1'b0);
        chk("fmt_set",  fmt_err,  1'b1);
        chk("fmt_med",  rec_med,  4'h3);
        chk("fmt_time", rec_time, 8'h70);
        repeat (10) @(negedge clk);
        chk("fmt_sticky", fmt_err, 1'b1);
        #1;
        rec_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("fmt_drained", rec_valid, 1'b0);
        chk("fmt_sticky2", fmt_err, 1'b1);

        // Start while busy is ignored.
        popped.delete();
        d0 = done_cnt;
        do_start(2);
        repeat (5) @(negedge clk);
        #1;
        start = 1'b1;
        count = 5'd5;
        @(negedge clk);
        #1;
        start = 1'b0;
        wait_idle(500, 1'b0);
        repeat (3) @(negedge clk);
        chk("busy_ign_count", popped.size(), 2);
        chk("busy_ign_done", done_cnt, d0 + 1);

        // A new start clears the sticky flag.
        do_start(0);
        wait_idle(20, 1'b0);
        chk("fmt_cleared", fmt_err, 1'b0);

        // Reset during the first PULSE_B.
        #1;
        rec_ready = 1'b0;
        d0 = done_cnt;
        a0 = ack_rises;
        do_start(3);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ack_rises >= a0 + 2) break;
        end
        chk("pb_ack_hi",  ack_out,   1'b1);
        chk("pb_valid",   rec_valid, 1'b1);
        #1;
        rst = 1'b1;
        #1;
        chk("pb_rst_ack", ack_out, 1'b0);
        @(negedge clk);
        @(negedge clk);
        #1;
        rst = 1'b0;
        repeat (30) @(negedge clk);
        chk("pb_busy",  busy,      1'b0);
        chk("pb_valid0", rec_valid, 1'b0);
        chk("pb_nodone", done_cnt, d0);

        // Randomised sequences with random back-pressure and stray starts.
        for (int s = 0; s < 30; s++) begin
            #1;
            rec_ready = ($urandom_range(0, 1) != 0);
            do_start(int'($urandom_range(0, 31)));
            wait_idle(4000, 1'b1);
            repeat ($urandom_range(0, 5)) @(negedge clk);
        end
        #1;
        start     = 1'b0;
        rec_ready = 1'b1;
        repeat (20) @(negedge clk);
        chk("final_drain", rec_valid, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
